// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute-stage ALU with valid/ready handshake and iterative HI/LO multiplier
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter bit MULT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               aluop,
  input  logic [5:0]               funct,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     overflow,
  output logic                     illegal,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ma, sum, diff, f_res;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH:0] acc;
  logic [5:0] op;
  logic neg, ovf_add, ovf_sub, f_ovf, f_ill, is_mul, is_signed, accept, done;
  assign sum      = a + b;
  assign diff     = a - b;
  assign ovf_add  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign in_ready = reset && state == IDLE && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // one extra MUL cycle after the WIDTH add-shift steps applies the sign fix
  assign done     = state == MUL && cnt == CW'(WIDTH);
  assign acc      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
  assign prod_fix = neg ? -prod : prod;
  // non-R-type aluops reuse the matching R-type funct decode
  assign op = aluop == 2'b10 ? funct : aluop == 2'b00 ? 6'b100000 : aluop == 2'b01 ? 6'b100010 : 6'b101010;
  always_comb begin
    f_res     = '0;
    f_ovf     = 1'b0;
    f_ill     = 1'b0;
    is_mul    = 1'b0;
    is_signed = 1'b0;
    case (op)
      6'b100000: begin f_res = sum; f_ovf = ovf_add; end
      6'b100010: begin f_res = diff; f_ovf = ovf_sub; end
      6'b100100: f_res = a & b;
      6'b100101: f_res = a | b;
      6'b100110: f_res = a ^ b;
      6'b100111: f_res = ~(a | b);
      6'b101010: f_res = WIDTH'($signed(a) < $signed(b));
      6'b101011: f_res = WIDTH'(a < b);
      6'b000000: f_res = b << shamt;
      6'b000010: f_res = b >> shamt;
      6'b000011: f_res = $signed(b) >>> shamt;
      6'b011000, 6'b011001: begin is_mul = MULT_EN; f_ill = !MULT_EN; is_signed = !op[0]; end
      6'b010000: begin f_res = MULT_EN ? hi : '0; f_ill = !MULT_EN; end
      6'b010010: begin f_res = MULT_EN ? lo : '0; f_ill = !MULT_EN; end
      default:   f_ill = 1'b1;
    endcase
  end
  always_comb state_n = state == IDLE ? (accept && is_mul ? MUL : IDLE) : (done ? IDLE : MUL);
  always_ff @(posedge clk) state <= !reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      ma        <= '0;
      prod      <= '0;
      neg       <= 1'b0;
    end else if (state == MUL) begin
      cnt  <= cnt + 1'b1;
      prod <= {acc, prod[WIDTH-1:1]};
      if (done) begin
        {hi, lo}  <= prod_fix;
        result    <= prod_fix[WIDTH-1:0];
        zero      <= prod_fix[WIDTH-1:0] == '0;
        overflow  <= 1'b0;
        illegal   <= 1'b0;
        out_valid <= 1'b1;
      end
    end else if (accept && is_mul) begin
      ma        <= is_signed && a[WIDTH-1] ? -a : a;
      prod      <= {{WIDTH{1'b0}}, (is_signed && b[WIDTH-1] ? -b : b)};
      neg       <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      result    <= f_res;
      zero      <= f_res == '0;
      overflow  <= f_ovf;
      illegal   <= f_ill;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized scoreboard bench for alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 1;
  logic [1:0] aluop = 0;
  logic [5:0] funct = 0;
  logic [4:0] shamt = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, zero, overflow, illegal;
  logic [31:0] result, hi, lo;
  typedef struct {
    logic [31:0] res;
    logic z, ov, il;
    logic [31:0] h, l;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_hi = 0, m_lo = 0;
  int nvec = 0, nerr = 0, cyc = 0, or_mode = 0;
  logic [5:0] fl[15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                         6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};

  alu_exec_unit #(.WIDTH(32), .MULT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // 0: always ready, 1: random back-pressure, 2: stalled
  always @(posedge clk) begin
    #2;
    out_ready = or_mode == 0 ? 1'b1 : or_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: MIPS semantics with wide integer arithmetic; HI/LO tracked as architectural state
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint s;
    logic [63:0] p;
    logic [5:0] k;
    k = op == 2'd2 ? f : op == 2'd0 ? 6'h20 : op == 2'd1 ? 6'h22 : 6'h2a;
    e.res = 0;
    e.ov = 0;
    e.il = 0;
    case (k)
      6'h20: begin s = longint'($signed(x)) + longint'($signed(y)); e.res = s[31:0]; e.ov = s != longint'($signed(s[31:0])); end
      6'h22: begin s = longint'($signed(x)) - longint'($signed(y)); e.res = s[31:0]; e.ov = s != longint'($signed(s[31:0])); end
      6'h24: e.res = x & y;
      6'h25: e.res = x | y;
      6'h26: e.res = x ^ y;
      6'h27: e.res = ~(x | y);
      6'h2a: e.res = {31'b0, ($signed(x) < $signed(y))};
      6'h2b: e.res = {31'b0, (x < y)};
      6'h00: e.res = y << sh;
      6'h02: e.res = y >> sh;
      6'h03: e.res = $signed(y) >>> sh;
      6'h18: begin p = longint'($signed(x)) * longint'($signed(y)); m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; end
      6'h19: begin p = {32'b0, x} * {32'b0, y}; m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; end
      6'h10: e.res = m_hi;
      6'h12: e.res = m_lo;
      default: e.il = 1;
    endcase
    e.z = e.res == 0;
    e.h = m_hi;
    e.l = m_lo;
    return e;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7fffffff;
      2: return 32'h80000000;
      3: return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] x, input logic [31:0] y);
    int w = 0;
    aluop = op; funct = f; shamt = sh; a = x; b = y; in_valid = 1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: in_ready %b required 1", in_ready);
    end else q.push_back(model(op, f, sh, x, y));
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_mul(input string name);
    int n = 0;
    logic saw = 0;
    while (!out_valid && n < 100) begin
      saw |= in_ready;
      @(posedge clk);
      #1 n++;
    end
    chk({name, "_latency"}, n, 33);
    chk({name, "_in_ready_low"}, saw, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_output: got result %h with no expected entry", result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("overflow", overflow, e.ov);
        chk("illegal", illegal, e.il);
        chk("hi", hi, e.h);
        chk("lo", lo, e.l);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, w;
    logic [5:0] f;
    logic [1:0] op;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", in_ready, 1);
    issue(2, 6'h20, 0, 32'h7fffffff, 32'h1);
    chk("add_ovf_valid", out_valid, 1);
    chk("add_ovf_result", result, 32'h80000000);
    chk("add_ovf_flag", overflow, 1);
    chk("add_ovf_zero", zero, 0);
    issue(2, 6'h03, 4, 32'h0, 32'hf0000000);
    chk("sra_result", result, 32'hff000000);
    issue(2, 6'h02, 4, 32'h0, 32'hf0000000);
    chk("srl_result", result, 32'h0f000000);
    issue(2, 6'h18, 0, 32'hfffffffd, 32'h5);
    wait_mul("mult");
    chk("mult_hi", hi, 32'hffffffff);
    chk("mult_lo", lo, 32'hfffffff1);
    issue(2, 6'h10, 0, 32'h0, 32'h0);
    chk("mfhi_result", result, 32'hffffffff);
    issue(2, 6'h19, 0, 32'hfffffffd, 32'h5);
    wait_mul("multu");
    chk("multu_hi", hi, 32'h00000004);
    chk("multu_lo", lo, 32'hfffffff1);
    @(posedge clk);
    or_mode = 2;
    #3;
    issue(2, 6'h22, 0, 32'h5, 32'h5);
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 0);
      chk("hold_zero", zero, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    or_mode = 0;
    @(posedge clk);
    #3 c0 = cyc;
    repeat (8) issue(2, 6'h20, 0, rnd32(), rnd32());
    chk("stream_cycles", cyc - c0, 8);
    issue(2, 6'h3f, 0, 32'h1234, 32'h5678);
    chk("illegal_flag", illegal, 1);
    chk("illegal_result", result, 0);
    chk("illegal_hi", hi, 32'h4);
    issue(3, 6'h3f, 0, 32'hffffffff, 32'h0);
    chk("slti_result", result, 1);
    issue(2, 6'h18, 0, rnd32(), rnd32());
    repeat (9) @(posedge clk);
    #1 chk("mid_mul_in_ready", in_ready, 0);
    reset = 0;
    @(posedge clk);
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_in_ready", in_ready, 0);
    q.delete();
    m_hi = 0;
    m_lo = 0;
    reset = 1;
    @(negedge clk);
    chk("abort_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1 or_mode = 1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) op = 2;
      w = $urandom_range(0, 15);
      f = w == 15 ? 6'($urandom) : fl[w];
      issue(op, f, 5'($urandom), rnd32(), rnd32());
    end
    or_mode = 0;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
